// File: rtl/acc_stage_pkg.sv
// Shared encodings, state type and default widths for the BIP accumulator stage.
package acc_stage_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned IMM_W_DEF  = 11;
   localparam int unsigned ADDR_W_DEF = 11;

   localparam logic [1:0] SEL_A_MEM = 2'b00;
   localparam logic [1:0] SEL_A_IMM = 2'b01;
   localparam logic [1:0] SEL_A_RES = 2'b10;
   localparam logic [1:0] SEL_A_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      EXEC   = 2'd2
   } state_e;

   // An instruction reads memory for a memory load or a memory-sourced B operand.
   function automatic logic needs_mem(input logic [1:0] sel_a, input logic sel_b);
      return (sel_a == SEL_A_MEM) || ((sel_a == SEL_A_RES) && !sel_b);
   endfunction

endpackage

// File: rtl/acc_stage_sign_ext.sv
// Sign extension of an IN_W-bit immediate to OUT_W bits (requires OUT_W > IN_W).
module sign_ext #(
   parameter int unsigned IN_W  = 11,
   parameter int unsigned OUT_W = 16
) (
   input  logic [IN_W-1:0]  i_in,
   output logic [OUT_W-1:0] o_out
);

   assign o_out = {{(OUT_W - IN_W){i_in[IN_W-1]}}, i_in};

endmodule

// File: rtl/acc_stage.sv
// BIP accumulator stage: ACC register, operand drive for the arit unit, memory read handshake.
// Optional overflow flag output o_ovf is built when ACC_OVF_FLAG_EN is defined.
module acc_stage
   import acc_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IMM_W  = IMM_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_sel_a,
   input  logic              i_sel_b,
   input  logic              i_wr_acc,
   input  logic              i_op,
   input  logic [IMM_W-1:0]  i_imm,
   output logic              o_mem_rd_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_rd_ack,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_acc,
   output logic [DATA_W-1:0] o_data,
   output logic              o_op,
   input  logic [DATA_W-1:0] i_res,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_zero,
   output logic              o_neg
`ifdef ACC_OVF_FLAG_EN
   ,
   output logic              o_ovf
`endif
);

   state_e              r_state;
   logic [1:0]          r_sel_a;
   logic                r_sel_b;
   logic                r_wr_acc;
   logic                r_op_lat;
   logic [IMM_W-1:0]    r_imm;
   logic [DATA_W-1:0]   r_mem_op;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_data;
   logic                r_op;
   logic                r_req;
   logic                r_busy;
   logic                r_done;

   logic [IMM_W-1:0]    w_imm_src;
   logic [DATA_W-1:0]   w_sext;
   logic                w_acc_we;
   logic [DATA_W-1:0]   w_acc_nxt;

   // In IDLE the operand is built from the live immediate so EXEC can be entered directly.
   assign w_imm_src = (r_state == IDLE) ? i_imm : r_imm;

   sign_ext #(
      .IN_W  (IMM_W),
      .OUT_W (DATA_W)
   ) u_sext (
      .i_in  (w_imm_src),
      .o_out (w_sext)
   );

   always_comb begin
      w_acc_we  = r_wr_acc && (r_sel_a != SEL_A_RSV);
      w_acc_nxt = i_res;
      case (r_sel_a)
         SEL_A_MEM: w_acc_nxt = r_mem_op;
         SEL_A_IMM: w_acc_nxt = w_sext;
         default:   w_acc_nxt = i_res;
      endcase
   end

`ifdef ACC_OVF_FLAG_EN
   logic r_ovf;
   logic w_ovf_nxt;

   assign w_ovf_nxt = (r_sel_a == SEL_A_RES) &&
                      (r_acc[DATA_W-1] == (r_data[DATA_W-1] ^ r_op)) &&
                      (i_res[DATA_W-1] != r_acc[DATA_W-1]);
   assign o_ovf     = r_ovf;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_sel_a  <= SEL_A_MEM;
         r_sel_b  <= 1'b0;
         r_wr_acc <= 1'b0;
         r_op_lat <= 1'b0;
         r_imm    <= '0;
         r_mem_op <= '0;
         r_acc    <= '0;
         r_data   <= '0;
         r_op     <= 1'b0;
         r_req    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_sel_a  <= i_sel_a;
                  r_sel_b  <= i_sel_b;
                  r_wr_acc <= i_wr_acc;
                  r_op_lat <= i_op;
                  r_imm    <= i_imm;
                  r_busy   <= 1'b1;
                  if (needs_mem(i_sel_a, i_sel_b)) begin
                     r_state <= MEM_RD;
                     r_req   <= 1'b1;
                  end else begin
                     r_state <= EXEC;
                     r_done  <= 1'b1;
                     r_data  <= i_sel_b ? w_sext : r_mem_op;
                     r_op    <= i_op;
                  end
               end
            end
            MEM_RD: begin
               if (i_mem_rd_ack) begin
                  r_mem_op <= i_mem_rdata;
                  r_state  <= EXEC;
                  r_req    <= 1'b0;
                  r_done   <= 1'b1;
                  r_data   <= r_sel_b ? w_sext : i_mem_rdata;
                  r_op     <= r_op_lat;
               end
            end
            EXEC: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               if (w_acc_we) begin
                  r_acc <= w_acc_nxt;
`ifdef ACC_OVF_FLAG_EN
                  r_ovf <= w_ovf_nxt;
`endif
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_mem_rd_req = r_req;
   assign o_mem_addr   = r_imm[ADDR_W-1:0];
   assign o_acc        = r_acc;
   assign o_data       = r_data;
   assign o_op         = r_op;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_zero       = (r_acc == '0);
   assign o_neg        = r_acc[DATA_W-1];

endmodule

// File: tb/tb_acc_stage.sv
// Self-checking bench for acc_stage: directed cases then randomized instructions vs. a model.
module tb_acc_stage;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [1:0]  i_sel_a = 2'b00;
   logic        i_sel_b = 1'b0;
   logic        i_wr_acc = 1'b0;
   logic        i_op = 1'b0;
   logic [10:0] i_imm = '0;
   logic        o_mem_rd_req;
   logic [10:0] o_mem_addr;
   logic        i_mem_rd_ack = 1'b0;
   logic [15:0] i_mem_rdata = '0;
   logic [15:0] o_acc;
   logic [15:0] o_data;
   logic        o_op;
   logic [15:0] i_res;
   logic        o_busy;
   logic        o_done;
   logic        o_zero;
   logic        o_neg;
`ifdef ACC_OVF_FLAG_EN
   logic        o_ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [15:0] m_acc = '0;
   logic [15:0] m_memop = '0;
   logic        m_memop_vld = 1'b0;
   logic        m_ovf = 1'b0;

   always #5 i_clk = ~i_clk;

   // Combinational arit unit
   assign i_res = o_op ? (o_acc - o_data) : (o_acc + o_data);

   acc_stage u_dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_sel_a      (i_sel_a),
      .i_sel_b      (i_sel_b),
      .i_wr_acc     (i_wr_acc),
      .i_op         (i_op),
      .i_imm        (i_imm),
      .o_mem_rd_req (o_mem_rd_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_rd_ack (i_mem_rd_ack),
      .i_mem_rdata  (i_mem_rdata),
      .o_acc        (o_acc),
      .o_data       (o_data),
      .o_op         (o_op),
      .i_res        (i_res),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_zero       (o_zero),
      .o_neg        (o_neg)
`ifdef ACC_OVF_FLAG_EN
      ,
      .o_ovf        (o_ovf)
`endif
   );

   function automatic logic [15:0] sext_m(input logic [10:0] imm);
      int v;
      v = int'(imm);
      if (v >= 1024) v = v - 2048;
      return 16'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_flags(input string tag);
      chk({tag, "/acc"}, 32'(o_acc), 32'(m_acc));
      chk({tag, "/zero"}, 32'(o_zero), 32'(m_acc == 16'd0));
      chk({tag, "/neg"}, 32'(o_neg), 32'(m_acc >= 16'h8000));
      chk({tag, "/busy"}, 32'(o_busy), 32'd0);
      chk({tag, "/done"}, 32'(o_done), 32'd0);
      chk({tag, "/req"}, 32'(o_mem_rd_req), 32'd0);
`ifdef ACC_OVF_FLAG_EN
      chk({tag, "/ovf"}, 32'(o_ovf), 32'(m_ovf));
`endif
   endtask

   // Issue one instruction from IDLE (called at a falling edge) and check it through to IDLE.
   task automatic run(input string tag, input logic [1:0] sa, input logic sb, input logic wr,
                      input logic op, input logic [10:0] imm, input int dly,
                      input logic [15:0] rd, input logic noise);
      logic [15:0] sx;
      logic [15:0] opb;
      logic        mem;
      int          s;
      sx  = sext_m(imm);
      mem = (sa == 2'd0) || (sa == 2'd2 && !sb);
      i_sel_a  = sa;
      i_sel_b  = sb;
      i_wr_acc = wr;
      i_op     = op;
      i_imm    = imm;
      i_start  = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      if (noise) begin
         i_sel_a  = 2'($urandom);
         i_sel_b  = 1'($urandom);
         i_wr_acc = 1'($urandom);
         i_op     = 1'($urandom);
         i_imm    = 11'($urandom);
      end
      if (mem) begin
         for (int c = 0; c < dly; c++) begin
            chk({tag, "/req"}, 32'(o_mem_rd_req), 32'd1);
            chk({tag, "/addr"}, 32'(o_mem_addr), 32'(imm));
            chk({tag, "/rd_busy"}, 32'(o_busy), 32'd1);
            chk({tag, "/rd_done"}, 32'(o_done), 32'd0);
            i_mem_rd_ack = (c == dly - 1);
            i_mem_rdata  = (c == dly - 1) ? rd : 16'($urandom);
            i_start      = noise ? 1'($urandom) : 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
         end
         i_mem_rd_ack = 1'b0;
         i_start      = 1'b0;
         m_memop      = rd;
         m_memop_vld  = 1'b1;
      end
      // EXEC cycle
      opb = sb ? sx : m_memop;
      chk({tag, "/done"}, 32'(o_done), 32'd1);
      chk({tag, "/ex_busy"}, 32'(o_busy), 32'd1);
      chk({tag, "/ex_req"}, 32'(o_mem_rd_req), 32'd0);
      chk({tag, "/op"}, 32'(o_op), 32'(op));
      chk({tag, "/ex_acc"}, 32'(o_acc), 32'(m_acc));
      if (sb || m_memop_vld) chk({tag, "/data"}, 32'(o_data), 32'(opb));
      if (noise) begin
         i_start      = 1'($urandom);
         i_mem_rd_ack = 1'($urandom);
         i_mem_rdata  = 16'($urandom);
      end
      if (wr && sa != 2'd3) begin
         case (sa)
            2'd0: begin m_acc = m_memop; m_ovf = 1'b0; end
            2'd1: begin m_acc = sx; m_ovf = 1'b0; end
            default: begin
               if (op) s = int'($signed(m_acc)) - int'($signed(opb));
               else    s = int'($signed(m_acc)) + int'($signed(opb));
               m_ovf = (s > 32767) || (s < -32768);
               m_acc = 16'(s);
            end
         endcase
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_start      = 1'b0;
      i_mem_rd_ack = 1'b0;
      chk_idle_flags(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      repeat (2) @(negedge i_clk);
      chk_idle_flags("reset");
      chk("reset/data", 32'(o_data), 32'd0);
      chk("reset/op", 32'(o_op), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk_idle_flags("reset_idle");

      run("ld_imm", 2'd1, 1'b0, 1'b1, 1'b0, 11'h7FF, 0, 16'h0, 1'b0);
      chk("ld_imm/val", 32'(o_acc), 32'hFFFF);
      run("ld_mem", 2'd0, 1'b0, 1'b1, 1'b0, 11'd5, 3, 16'h0006, 1'b0);
      chk("ld_mem/val", 32'(o_acc), 32'h0006);
      run("add_mem", 2'd2, 1'b0, 1'b1, 1'b0, 11'd9, 1, 16'h0001, 1'b0);
      chk("add_mem/val", 32'(o_acc), 32'h0007);
      run("ld_f", 2'd1, 1'b0, 1'b1, 1'b0, 11'h00F, 0, 16'h0, 1'b0);
      run("sub_imm", 2'd2, 1'b1, 1'b1, 1'b1, 11'd5, 0, 16'h0, 1'b0);
      chk("sub_imm/val", 32'(o_acc), 32'h000A);

      // Signed overflow boundary and its clearing by a load
      run("ld_7fff", 2'd0, 1'b0, 1'b1, 1'b0, 11'd7, 2, 16'h7FFF, 1'b0);
      run("ovf_add", 2'd2, 1'b1, 1'b1, 1'b0, 11'd1, 0, 16'h0, 1'b0);
      chk("ovf_add/val", 32'(o_acc), 32'h8000);
      run("ld_zero", 2'd1, 1'b1, 1'b1, 1'b0, 11'd0, 0, 16'h0, 1'b0);
      chk("ld_zero/zero", 32'(o_zero), 32'd1);

      // No write: wr_acc clear, and the reserved source with wr_acc set
      run("ld_123", 2'd1, 1'b0, 1'b1, 1'b0, 11'h123, 0, 16'h0, 1'b0);
      run("no_wr", 2'd1, 1'b1, 1'b0, 1'b0, 11'h055, 0, 16'h0, 1'b0);
      run("rsv", 2'd3, 1'b1, 1'b1, 1'b1, 11'h066, 0, 16'h0, 1'b0);
      chk("rsv/val", 32'(o_acc), 32'h0123);

      // Asynchronous reset in MEM_RD with a start pulsed while busy
      i_sel_a = 2'd0;
      i_sel_b = 1'b0;
      i_wr_acc = 1'b1;
      i_imm = 11'd9;
      i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b1;
      chk("rst_rd/req", 32'(o_mem_rd_req), 32'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      chk("rst_rd/req_hold", 32'(o_mem_rd_req), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_rd/req_drop", 32'(o_mem_rd_req), 32'd0);
      chk("rst_rd/acc", 32'(o_acc), 32'd0);
      chk("rst_rd/busy", 32'(o_busy), 32'd0);
      m_acc = '0;
      m_ovf = 1'b0;
      m_memop_vld = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);
      chk_idle_flags("rst_after");

      // Randomized instructions with noise on ignored inputs
      for (int n = 0; n < 150; n++) begin
         run("rnd", 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
             11'($urandom), $urandom_range(1, 4), 16'($urandom), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
